// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padding front end.
package sha256_pkg;

    localparam int          SHA_BLOCK_WORDS = 16;
    localparam logic [31:0] SHA_PAD_WORD    = 32'h8000_0000;

    // Word 0 of a block is element [0]; each element is one 32-bit word.
    typedef logic [SHA_BLOCK_WORDS-1:0][31:0] sha_block_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_OFFER = 2'd2,
        ST_FIN   = 2'd3
    } pad_state_t;

    // Message words + marker word + two length words, rounded up to whole blocks.
    function automatic int num_padded_blocks(input int n);
        return (n + 18) / 16;
    endfunction

endpackage

// File: rtl/sha256_pad_slot.sv
// Padding rule for one block slot: message word, 0x80000000 marker, zero fill, or length.
// Purely combinational, zero latency; no handshake.
module sha256_pad_slot
    import sha256_pkg::*;
(
    input  logic [15:0] g,
    input  logic [15:0] n,
    input  logic        is_last,
    input  logic [3:0]  slot,
    input  logic [31:0] mem_word,
    output logic [31:0] slot_word
);

    logic [31:0] len_word;

    // Bit length of the message; n never exceeds 1024, so the high length word is zero.
    assign len_word = {11'b0, n, 5'b0};

    always_comb begin
        slot_word = '0;
        if (g < n) begin
            slot_word = mem_word;
        end else if (g == n) begin
            slot_word = SHA_PAD_WORD;
        end else if (is_last && slot == 4'(SHA_BLOCK_WORDS - 2)) begin
            slot_word = '0;
        end else if (is_last && slot == 4'(SHA_BLOCK_WORDS - 1)) begin
            slot_word = len_word;
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Fetches a message from synchronous memory and offers SHA-256 padded 512-bit blocks.
// 17 cycles to fill each block; block held stable on blk_valid until blk_ready.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    input  logic [31:0] mem_read_data,
    output sha_block_t  blk_data,
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic        blk_last,
    output logic [7:0]  blk_idx,
    output logic        busy,
    output logic        done
);

    localparam int          NUM_BLOCKS = num_padded_blocks(NUM_OF_WORDS);
    localparam logic [15:0] MSG_WORDS  = 16'(NUM_OF_WORDS);
    localparam logic [7:0]  LAST_IDX   = 8'(NUM_BLOCKS - 1);

    pad_state_t  state, state_nxt;
    logic [4:0]  cnt;
    logic [7:0]  blk_idx_q;
    logic [15:0] base_q;
    logic [15:0] addr_q;
    sha_block_t  blk_q;

    logic [15:0] blk_off;
    logic [15:0] rd_g;
    logic [3:0]  wr_slot;
    logic [15:0] wr_g;
    logic        is_last;
    logic        fill_done;
    logic        rd_en;
    logic [31:0] slot_word;

    assign blk_off   = {4'b0, blk_idx_q, 4'b0};
    assign rd_g      = blk_off + {12'b0, cnt[3:0]};
    // Slot written in cycle c is c-1; at c=16 the low bits wrap to give slot 15.
    assign wr_slot   = cnt[3:0] - 4'd1;
    assign wr_g      = blk_off + {12'b0, wr_slot};
    assign is_last   = (blk_idx_q == LAST_IDX);
    assign fill_done = (cnt == 5'd16);

    sha256_pad_slot u_pad_slot (
        .g         (wr_g),
        .n         (MSG_WORDS),
        .is_last   (is_last),
        .slot      (wr_slot),
        .mem_word  (mem_read_data),
        .slot_word (slot_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FILL;
            ST_FILL:  if (fill_done) state_nxt = ST_OFFER;
            ST_OFFER: if (blk_ready) state_nxt = is_last ? ST_FIN : ST_FILL;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        blk_valid = (state == ST_OFFER);
        blk_last  = (state == ST_OFFER) && is_last;
        busy      = (state == ST_FILL) || (state == ST_OFFER);
        done      = (state == ST_FIN);
        mem_we    = 1'b0;
        // Reads stop at the last message word; the address then simply holds.
        rd_en     = (state == ST_FILL) && !cnt[4] && (rd_g < MSG_WORDS);
        mem_addr  = rd_en ? (base_q + rd_g) : addr_q;
        blk_data  = blk_q;
        blk_idx   = blk_idx_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            blk_idx_q <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            blk_q     <= '0;
        end else begin
            addr_q <= mem_addr;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q    <= message_addr;
                        blk_idx_q <= '0;
                        cnt       <= '0;
                    end
                end
                ST_FILL: begin
                    if (cnt != 5'd0) begin
                        blk_q[wr_slot] <= slot_word;
                    end
                    cnt <= fill_done ? 5'd0 : cnt + 5'd1;
                end
                ST_OFFER: begin
                    if (blk_ready && !is_last) begin
                        blk_idx_q <= blk_idx_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: four instances (N = 1, 13, 14, 20) share one memory image.
module tb_sha256_msg_padder;
    import sha256_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [3:0]  start;
    logic [3:0]  ready;
    logic [15:0] msg_addr [4];
    logic [15:0] maddr    [4];
    logic [3:0]  we;
    logic [31:0] rdata    [4];
    sha_block_t  bdata    [4];
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [7:0]  idx      [4];
    logic [3:0]  busy;
    logic [3:0]  done;

    logic [31:0] mem [0:65535];

    typedef struct {
        sha_block_t  data;
        logic        last;
        logic [7:0]  idx;
    } exp_t;
    exp_t sbq[$];

    int n_chk  = 0;
    int n_fail = 0;
    int addr_bad [4] = '{0, 0, 0, 0};
    int wrap_seen[4] = '{0, 0, 0, 0};
    logic [15:0] cur_base [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
    int          cur_n    [4] = '{1, 13, 14, 20};

    sha256_msg_padder #(.NUM_OF_WORDS(1)) u_n1 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .message_addr(msg_addr[0]),
        .mem_addr(maddr[0]), .mem_we(we[0]), .mem_read_data(rdata[0]),
        .blk_data(bdata[0]), .blk_valid(valid[0]), .blk_ready(ready[0]),
        .blk_last(last[0]), .blk_idx(idx[0]), .busy(busy[0]), .done(done[0]));

    sha256_msg_padder #(.NUM_OF_WORDS(13)) u_n13 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .message_addr(msg_addr[1]),
        .mem_addr(maddr[1]), .mem_we(we[1]), .mem_read_data(rdata[1]),
        .blk_data(bdata[1]), .blk_valid(valid[1]), .blk_ready(ready[1]),
        .blk_last(last[1]), .blk_idx(idx[1]), .busy(busy[1]), .done(done[1]));

    sha256_msg_padder #(.NUM_OF_WORDS(14)) u_n14 (
        .clk(clk), .reset_n(reset_n), .start(start[2]), .message_addr(msg_addr[2]),
        .mem_addr(maddr[2]), .mem_we(we[2]), .mem_read_data(rdata[2]),
        .blk_data(bdata[2]), .blk_valid(valid[2]), .blk_ready(ready[2]),
        .blk_last(last[2]), .blk_idx(idx[2]), .busy(busy[2]), .done(done[2]));

    sha256_msg_padder #(.NUM_OF_WORDS(20)) u_n20 (
        .clk(clk), .reset_n(reset_n), .start(start[3]), .message_addr(msg_addr[3]),
        .mem_addr(maddr[3]), .mem_we(we[3]), .mem_read_data(rdata[3]),
        .blk_data(bdata[3]), .blk_valid(valid[3]), .blk_ready(ready[3]),
        .blk_last(last[3]), .blk_idx(idx[3]), .busy(busy[3]), .done(done[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read memory: data appears one cycle after the address.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) rdata[k] <= mem[maddr[k]];
    end

    // Address monitor: any read offset at or beyond N while busy is an over-read.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (busy[k]) begin
                if (int'(16'(maddr[k] - cur_base[k])) >= cur_n[k]) addr_bad[k]++;
                if (maddr[k] == 16'h0000 && cur_base[k] == 16'hFFF8) wrap_seen[k]++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic sha_block_t exp_block(input int n, input logic [15:0] base, input int b);
        sha_block_t blk;
        int nb;
        int g;
        nb = (n + 18) / 16;
        for (int s = 0; s < 16; s++) begin
            g = b * 16 + s;
            if (g < n)                     blk[s] = mem[16'(base + 16'(g))];
            else if (g == n)               blk[s] = 32'h8000_0000;
            else if (b == nb - 1 && s == 15) blk[s] = 32'(n * 32);
            else                           blk[s] = 32'h0;
        end
        return blk;
    endfunction

    task automatic run_msg(input int k, input int n, input logic [15:0] base, input int hold);
        int   nb;
        int   edges;
        int   bad0;
        exp_t e;
        logic [15:0] snap;
        nb = (n + 18) / 16;
        for (int b = 0; b < nb; b++) begin
            e.data = exp_block(n, base, b);
            e.last = (b == nb - 1);
            e.idx  = 8'(b);
            sbq.push_back(e);
        end
        cur_base[k] = base;
        bad0        = addr_bad[k];
        msg_addr[k] = base;
        ready[k]    = (hold == 0);
        @(negedge clk);
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        check($sformatf("busy_on%0d", k), 32'(busy[k]), 32'd1);
        for (int b = 0; b < nb; b++) begin
            edges = 0;
            while (!valid[k] && edges < 40) begin
                @(posedge clk); #1;
                edges++;
            end
            check($sformatf("lat%0d_b%0d", k, b), 32'(edges), 32'd17);
            e = sbq.pop_front();
            if (hold > 0 && b == 0) begin
                snap = maddr[k];
                start[k] = 1'b1;
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                end
                start[k] = 1'b0;
                check("bp_vld",  32'(valid[k]), 32'd1);
                check("bp_addr", 32'(maddr[k]), 32'(snap));
                check("bp_idx",  32'(idx[k]), 32'(e.idx));
                check("bp_last", 32'(last[k]), 32'(e.last));
                ready[k] = 1'b1;
            end
            for (int s = 0; s < 16; s++)
                check($sformatf("dat%0d_b%0d_w%0d", k, b, s), bdata[k][s], e.data[s]);
            check($sformatf("last%0d_b%0d", k, b), 32'(last[k]), 32'(e.last));
            check($sformatf("idx%0d_b%0d", k, b), 32'(idx[k]), 32'(e.idx));
            @(posedge clk); #1;
            check($sformatf("vld_drop%0d_b%0d", k, b), 32'(valid[k]), 32'd0);
        end
        check($sformatf("done%0d", k), 32'(done[k]), 32'd1);
        check($sformatf("busy_off%0d", k), 32'(busy[k]), 32'd0);
        @(posedge clk); #1;
        check($sformatf("done_pulse%0d", k), 32'(done[k]), 32'd0);
        check($sformatf("addr_rng%0d", k), 32'(addr_bad[k] - bad0), 32'd0);
        ready[k] = 1'b0;
    endtask

    task automatic check_reset_state(input int k);
        check($sformatf("r_vld%0d", k),  32'(valid[k]), 32'd0);
        check($sformatf("r_last%0d", k), 32'(last[k]),  32'd0);
        check($sformatf("r_idx%0d", k),  32'(idx[k]),   32'd0);
        check($sformatf("r_busy%0d", k), 32'(busy[k]),  32'd0);
        check($sformatf("r_done%0d", k), 32'(done[k]),  32'd0);
        check($sformatf("r_addr%0d", k), 32'(maddr[k]), 32'd0);
        check($sformatf("r_we%0d", k),   32'(we[k]),    32'd0);
        check($sformatf("r_dat%0d", k),  32'(|bdata[k]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        for (int i = 0; i < 65536; i++) mem[i] = {16'hC0DE ^ 16'(i), 16'(i)} ^ 32'h1357_9BDF;
        mem[16'h0100] = 32'h6162_6364;
        reset_n = 1'b0;
        start   = '0;
        ready   = '0;
        for (int k = 0; k < 4; k++) msg_addr[k] = 16'h0;
        #12;
        for (int k = 0; k < 4; k++) check_reset_state(k);
        @(negedge clk);
        reset_n = 1'b1;

        run_msg(0, 1, 16'h0100, 0);
        check("n1_w0",  bdata[0][0],  32'h6162_6364);
        check("n1_w1",  bdata[0][1],  32'h8000_0000);
        check("n1_w15", bdata[0][15], 32'h0000_0020);

        run_msg(1, 13, 16'h0300, 0);
        check("n13_w13", bdata[1][13], 32'h8000_0000);
        check("n13_w15", bdata[1][15], 32'h0000_01A0);

        run_msg(2, 14, 16'h0500, 5);
        check("n14_w15", bdata[2][15], 32'h0000_01C0);

        w0 = wrap_seen[3];
        run_msg(3, 20, 16'hFFF8, 0);
        check("n20_wrap", 32'(wrap_seen[3] > w0), 32'd1);
        check("n20_w0",   bdata[3][0],  mem[16'h0008]);
        check("n20_w4",   bdata[3][4],  32'h8000_0000);
        check("n20_w15",  bdata[3][15], 32'h0000_0280);

        // Abort mid-fill: reset lands in FILL cycle c=7 of block 0.
        msg_addr[3] = 16'h0040;
        @(negedge clk);
        start[3] = 1'b1;
        @(posedge clk); #1;
        start[3] = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state(3);
        @(negedge clk);
        reset_n = 1'b1;

        run_msg(3, 20, 16'h0200, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
